// File: rtl/regfile_sb.sv
// regfile_sb
// Register file with a per-register scoreboard ("busy") bit and a bulk-clear
// sequencer. Register 0 is hardwired to zero and can never be marked busy.
//
// Ports
//   clk, rst            : clock (rising edge) and asynchronous active-high reset
//   ce, writeAddr,
//   dataIn              : write port; a write also clears the target busy bit
//   read1Addr/out1/busy1,
//   read2Addr/out2/busy2: two combinational read ports (data + busy bit)
//   rsvValid, rsvAddr   : reservation port; marks a destination pending
//   clrReq, clrBusy     : start a bulk clear of r1..r(NREGS-1); clrBusy is high
//                         for the whole sequence
//
// Build option
//   REGFILE_BYPASS_EN   : when defined, a write in progress is forwarded to a
//                         read port addressing the same register in the same
//                         cycle. When undefined, reads show the stored value.

module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [AW-1:0]   writeAddr,
  input  logic [XLEN-1:0] dataIn,
  input  logic [AW-1:0]   read1Addr,
  input  logic [AW-1:0]   read2Addr,
  output logic [XLEN-1:0] out1,
  output logic [XLEN-1:0] out2,
  input  logic            rsvValid,
  input  logic [AW-1:0]   rsvAddr,
  output logic            busy1,
  output logic            busy2,
  input  logic            clrReq,
  output logic            clrBusy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   cnt, cnt_next;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic clr_active;
  logic wr_en;
  logic rsv_en;

  // The clear sequence owns the array, so normal writes and reservations are
  // suppressed while it runs. Address 0 is filtered out here once.
  assign clr_active = (state == CLEAR);
  assign clrBusy    = clr_active;
  assign wr_en      = ce && !clr_active && (writeAddr != '0);
  assign rsv_en     = rsvValid && !clr_active && (rsvAddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Clear walks cnt from 1 up to NREGS-1 and then stops; cnt holds its last
  // value afterwards rather than wrapping back to 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clrReq) begin
          state_next = CLEAR;
          cnt_next   = AW'(1);
        end
      end
      CLEAR: begin
        if (cnt == AW'(NREGS - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data array. Entry 0 is only ever loaded by reset, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (clr_active && (cnt == AW'(i))) begin
          regs[i] <= '0;
        end else if (wr_en && (writeAddr == AW'(i))) begin
          regs[i] <= dataIn;
        end
      end
    end
  end

  // Scoreboard bits. A reservation takes priority over a write that lands on
  // the same register in the same cycle: the result is pending again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (clr_active && (cnt == AW'(i))) begin
          busy[i] <= 1'b0;
        end else if (rsv_en && (rsvAddr == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_en && (writeAddr == AW'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports. Outputs are forced to zero while reset is asserted so that no
  // bypassed write data can leak out during reset.
  always_comb begin
    out1  = '0;
    busy1 = 1'b0;
    if (!rst && (read1Addr != '0)) begin
      out1  = regs[read1Addr];
      busy1 = busy[read1Addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (writeAddr == read1Addr)) begin
        out1  = dataIn;
        busy1 = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    out2  = '0;
    busy2 = 1'b0;
    if (!rst && (read2Addr != '0)) begin
      out2  = regs[read2Addr];
      busy2 = busy[read2Addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (writeAddr == read2Addr)) begin
        out2  = dataIn;
        busy2 = 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register in bits.
REQ-002 Parameter NREGS, default 32: register count, a power of two, at least 4.
REQ-003 Derived localparam AW = $clog2(NREGS): address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ce  in  1  write enable.
REQ-007 writeAddr  in  AW  write destination.
REQ-008 dataIn  in  XLEN  write data.
REQ-009 read1Addr, read2Addr  in  AW  read-port addresses.
REQ-010 out1, out2  out  XLEN  read data; combinational from address.
REQ-011 rsvValid  in  1  reserve a destination; marks it pending.
REQ-012 rsvAddr  in  AW  register to reserve.
REQ-013 busy1, busy2  out  1  scoreboard bit of read1Addr / read2Addr; combinational.
REQ-014 clrReq  in  1  start a bulk-clear sequence.
REQ-015 clrBusy  out  1  high while a bulk clear is in progress.

Function
REQ-016 Register 0 reads as 0 on both ports; writes to it are ignored; reservations of it are ignored; its busy bit always reads 0.
REQ-017 Write: at a rising edge with ce=1, clrBusy=0 and writeAddr!=0, regs[writeAddr] <= dataIn and busy[writeAddr] <= 0.
REQ-018 Reads have zero latency: outN = regs[readNAddr] and busyN = busy[readNAddr] in the same cycle.
REQ-019 Reserve: at a rising edge with rsvValid=1, clrBusy=0 and rsvAddr!=0, busy[rsvAddr] <= 1.
REQ-020 Simultaneous write and reserve to the same address: the data is written and busy ends at 1 (the reservation wins).
REQ-021 Writes and reservations to different addresses in the same cycle both take effect.
REQ-022 The clear FSM has two states: IDLE and CLEAR.
REQ-023 In IDLE with clrReq=1: go to CLEAR and load the counter with 1.
REQ-024 In CLEAR, each cycle: regs[cnt] <= 0, busy[cnt] <= 0, then cnt <= cnt+1.
REQ-025 When cnt = NREGS-1, that register is cleared and the FSM returns to IDLE; CLEAR lasts exactly NREGS-1 cycles.
REQ-026 clrBusy = 1 exactly while the FSM is in CLEAR.
REQ-027 During CLEAR: ce, rsvValid and clrReq are ignored; reads stay functional and return the partly cleared contents.
REQ-028 The counter is AW bits wide and never wraps past NREGS-1.

Reset
REQ-029 While rst=1, asynchronously: all registers are 0, all busy bits are 0, the FSM is IDLE, the counter is 0 and clrBusy is 0.
REQ-030 Assertion of rst in the middle of CLEAR aborts the sequence; after release the FSM is IDLE and the contents are all zero.
REQ-031 out1, out2, busy1 and busy2 read 0 for every address while rst=1.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN controls write-to-read forwarding.
REQ-033 With REGFILE_BYPASS_EN defined: when ce=1, clrBusy=0, writeAddr!=0 and writeAddr = readNAddr, then outN = dataIn and busyN = 0 in the same cycle.
REQ-034 Without REGFILE_BYPASS_EN: outN shows the stored value, and the new value appears in the cycle after the write edge.

Verification
REQ-035 Write 0xDEADBEEF to r5, then read r5 on port 1 and r0 on port 2 -> out1=0xDEADBEEF, out2=0.
REQ-036 Reserve r7, then read r7 -> busy1=1; then write 0x12 to r7 -> busy1=0 and out1=0x12 on the next cycle.
REQ-037 In one cycle, ce=1 with writeAddr=3 and rsvValid=1 with rsvAddr=3 -> regs[3]=dataIn and busy[3]=1.
REQ-038 Fill r1..r31, pulse clrReq -> clrBusy high for exactly 31 cycles, all registers 0 afterwards, and a write attempted during the clear is lost.
REQ-039 Assert rst at cycle 10 of a clear -> clrBusy=0 immediately, and after release r20 reads 0 and a new write to r20 succeeds.
REQ-040 With REGFILE_BYPASS_EN: ce=1, writeAddr=9, dataIn=0xA5, read1Addr=9 -> out1=0xA5 in the same cycle; without the macro -> out1 holds the old value in that cycle.
